mc_alu: RTL and testbench
=========================

# mc_alu

Parametrised multi-cycle arithmetic/logic unit for the multi-cycle CPU datapath, succeeding the single-cycle combinational ALU. It runs ADD/SUB/OR/AND/XOR/SLT in one cycle, variable shifts bit-serially, and unsigned multiply (plus optional unsigned divide) iteratively. Control uses a start/busy/done handshake. Results, flags and the high word are registered and held until the next accepted operation.

## Interface

Parameters:
- WIDTH, 32: operand and result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only on an edge where busy=0.
- op  in  4  operation, sampled on accept:
  - 0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 XOR, 0101 SLT (signed).
  - 0110 SLL, 0111 SRL (amount b[SHW-1:0]).
  - 1000 MULU, 1001 DIVU.
- a, b  in  WIDTH  operands, sampled on accept; ignored afterwards.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when result/flags are valid.
- result  out  WIDTH  low result: sum/logic/shift/product-low/quotient.
- result_hi  out  WIDTH  product high word or remainder; 0 for other ops.
- zero  out  1  result==0, registered with result.
- overflow  out  1  signed overflow (ADD/SUB), product_hi≠0 (MULU), divide-by-zero (DIVU).

## Operation

- FSM states are IDLE and RUN; busy = (state==RUN).
- IDLE with start=1:
  - For ADD/SUB/OR/AND/XOR/SLT, shift with amount 0, illegal op, and DIVU with b=0: compute directly, register outputs, pulse done, stay IDLE.
  - All other ops: latch operands, load the cycle counter, enter RUN.
- RUN, shifts: shift one bit per cycle, counter = amount. When the counter reaches 0, register outputs, pulse done, return to IDLE.
- RUN, MULU: shift-add, one multiplier bit per cycle, WIDTH cycles. Output is the 2·WIDTH product split into {result_hi, result}.
- RUN, DIVU: restoring division, one quotient bit per cycle, WIDTH cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ADD overflow = (a[W-1]==b[W-1]) && (res[W-1]!=a[W-1]).
  - SUB overflow = (a[W-1]!=b[W-1]) && (res[W-1]!=a[W-1]).
  - SLT result is 1 or 0, zero-extended; overflow=0.
  - Logic ops and shifts: overflow=0.
- Illegal op (1010–1111, or 1001 without the macro): result=0, result_hi=0, zero=1, overflow=0, latency 1.
- DIVU with b=0: result=all ones, result_hi=a, overflow=1, latency 1.
- start while busy=1 is ignored; the operation in flight is unaffected.
- result/result_hi/zero/overflow change only on the edge that raises done; otherwise they hold.

## Timing

- Reset (async assert): state=IDLE, busy=0, done=0, result=0, result_hi=0, zero=1, overflow=0.
- Release of rst_n is synchronised by the system; the first edge after release may accept start.
- Latency L is counted from the accepting edge k to the edge that raises done (done high for the cycle after edge k+L−1):
  - single-cycle ops: L=1
  - shift by s≥1: L=s+1
  - MULU, DIVU (b≠0): L=WIDTH+1
- busy is high from after edge k until the edge raising done. In the done cycle busy=0, so back-to-back start is accepted then.
- Reset mid-RUN aborts the operation immediately; no done pulse is produced.

## Configuration

- MC_ALU_DIV_EN defined: op 1001 performs iterative unsigned divide as above.
- MC_ALU_DIV_EN undefined: divider datapath is not built; op 1001 behaves as an illegal op.

## Test plan

- ADD, WIDTH=32: a=0x7FFFFFFF, b=1, start → done after 1 edge; result=0x80000000, overflow=1, zero=0. Then SUB a=5, b=5 → result=0, zero=1.
- SLL a=0x1, b=31 → busy 31 cycles, done at L=32, result=0x80000000. SRL with b=0 → L=1, result=a.
- MULU a=0xFFFFFFFF, b=2 → done at L=33; result=0xFFFFFFFE, result_hi=1, overflow=1. A start pulsed mid-operation is ignored.
- DIVU (macro on) a=100, b=7 → L=33; result=14, result_hi=2. DIVU with b=0 → L=1, result=0xFFFFFFFF, result_hi=100, overflow=1. Macro off: op 1001 → result=0, zero=1.
- Assert rst_n=0 mid-MULU at cycle 10 → busy=0 and outputs at reset values immediately; no done pulse. A new ADD after release completes normally.
- Back-to-back: issue AND in the done cycle of a prior ADD → accepted; second done exactly 1 edge later.

Source files
------------

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU. ADD/SUB/logic/SLT take 1 cycle; shifts go bit-serially; MULU (and DIVU) are iterative.
// Latency: 1 for single-cycle ops, s+1 for a shift by s>=1, WIDTH+1 for MULU and for DIVU with b!=0.
// Backpressure: start is accepted only while busy=0. Results are held until the next accepted op. Define MC_ALU_DIV_EN to build the divider.
module mc_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product high word / partial remainder. lo: shift value / multiplier / quotient.
  // opb: multiplicand / divisor.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH:0]   mul_add;
  logic             fin;
  logic [WIDTH-1:0] fin_res, fin_hi;
  logic             fin_ovf;

  assign sum     = a + b;
  assign diff    = a - b;
  // One shift-add step: add the multiplicand to the high word when the current multiplier bit is set.
  assign mul_add = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

`ifdef MC_ALU_DIV_EN
  logic [WIDTH:0] div_sh, div_sub;
  // Restoring step: bring the next dividend bit into the remainder and trial-subtract the divisor.
  assign div_sh  = {acc_q, lo_q[WIDTH-1]};
  assign div_sub = div_sh - {1'b0, opb_q};
`endif

  // Next-state logic: accept/compute in IDLE, iterate in RUN, and register the outputs on completion.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    fin         = 1'b0;
    fin_res     = '0;
    fin_hi      = '0;
    fin_ovf     = 1'b0;

    if (state_q == S_IDLE) begin
      if (start) begin
        op_d = op;
        unique case (op)
          OP_ADD: begin
            fin     = 1'b1;
            fin_res = sum;
            fin_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SUB: begin
            fin     = 1'b1;
            fin_res = diff;
            fin_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
          end
          OP_OR:  begin fin = 1'b1; fin_res = a | b; end
          OP_AND: begin fin = 1'b1; fin_res = a & b; end
          OP_XOR: begin fin = 1'b1; fin_res = a ^ b; end
          OP_SLT: begin
            fin     = 1'b1;
            fin_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          end
          OP_SLL, OP_SRL: begin
            if (b[SHW-1:0] == '0) begin
              fin     = 1'b1;
              fin_res = a;
            end else begin
              lo_d    = a;
              cnt_d   = {1'b0, b[SHW-1:0]};
              state_d = S_RUN;
            end
          end
          OP_MULU: begin
            acc_d   = '0;
            lo_d    = a;
            opb_d   = b;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end
`ifdef MC_ALU_DIV_EN
          OP_DIVU: begin
            if (b == '0) begin
              fin     = 1'b1;
              fin_res = '1;
              fin_hi  = a;
              fin_ovf = 1'b1;
            end else begin
              acc_d   = '0;
              lo_d    = a;
              opb_d   = b;
              cnt_d   = CW'(WIDTH);
              state_d = S_RUN;
            end
          end
`endif
          default: fin = 1'b1;
        endcase
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      unique case (op_q)
        OP_SLL: lo_d = {lo_q[WIDTH-2:0], 1'b0};
        OP_SRL: lo_d = {1'b0, lo_q[WIDTH-1:1]};
        OP_MULU: {acc_d, lo_d} = {mul_add, lo_q[WIDTH-1:1]};
`ifdef MC_ALU_DIV_EN
        OP_DIVU: begin
          if (!div_sub[WIDTH]) begin
            acc_d = div_sub[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_sh[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
`endif
        default: ;
      endcase
      if (cnt_q == CW'(1)) begin
        fin     = 1'b1;
        fin_res = lo_d;
        fin_hi  = (op_q == OP_SLL || op_q == OP_SRL) ? '0 : acc_d;
        fin_ovf = (op_q == OP_MULU) && (acc_d != '0);
      end
    end

    if (fin) begin
      state_d     = S_IDLE;
      result_d    = fin_res;
      result_hi_d = fin_hi;
      zero_d      = (fin_res == '0);
      overflow_d  = fin_ovf;
      done_d      = 1'b1;
    end
  end

  // State, datapath and registered outputs; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mc_alu.sv
// Bench for mc_alu (WIDTH=32): directed vector table, multi-cycle corner sequences,
// and random ops checked against a plain-arithmetic reference model.
module tb_mc_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero, overflow;
  logic [31:0] result, result_hi;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .overflow(overflow)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r, h;
    logic        v;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: straight arithmetic on the operation's definition.
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic [31:0] h, output logic v, output int l);
    longint s;
    logic [63:0] p;
    r = '0; h = '0; v = 1'b0; l = 1;
    case (o)
      4'd0: begin r = x + y; s = longint'($signed(x)) + longint'($signed(y)); v = (s != longint'($signed(r))); end
      4'd1: begin r = x - y; s = longint'($signed(x)) - longint'($signed(y)); v = (s != longint'($signed(r))); end
      4'd2: r = x | y;
      4'd3: r = x & y;
      4'd4: r = x ^ y;
      4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: begin r = x << y[4:0]; l = (y[4:0] == 0) ? 1 : int'(y[4:0]) + 1; end
      4'd7: begin r = x >> y[4:0]; l = (y[4:0] == 0) ? 1 : int'(y[4:0]) + 1; end
      4'd8: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; h = p[63:32]; v = (h != 0); l = 33; end
`ifdef MC_ALU_DIV_EN
      4'd9: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; h = x; v = 1'b1; l = 1; end
        else begin r = x / y; h = x % y; l = 33; end
      end
`endif
      default: ;
    endcase
  endtask

  // Issue one op at a negedge and count edges until done. Optionally pulse an
  // ADD start `poke` cycles into the operation, which must be ignored.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int poke, output int lat, output bit busy_ok);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; busy_ok = 1'b1;
    a = $urandom; b = $urandom;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      start = (lat == poke);
      if (lat == poke) begin op = 4'd0; a = 32'd1; b = 32'd1; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic [31:0] h, input logic v, input int l, input int poke);
    int lat;
    bit bok;
    do_op(o, x, y, poke, lat, bok);
    chk({name, ".lat"}, 64'(lat), 64'(l));
    chk({name, ".result"}, 64'(result), 64'(r));
    chk({name, ".result_hi"}, 64'(result_hi), 64'(h));
    chk({name, ".zero"}, 64'(zero), 64'(r == 0));
    chk({name, ".overflow"}, 64'(overflow), 64'(v));
    chk({name, ".busy"}, 64'(bok), 64'd1);
  endtask

  initial begin
    logic [31:0] er, eh;
    logic ev;
    int el;
    bit seen_done;
    logic [3:0] ro;
    logic [31:0] ra, rb;

    //        op     a             b             result        hi            ovf  lat
    vecs.push_back('{4'd0, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 32'd0,       1'b1, 1});
    vecs.push_back('{4'd1, 32'd5,         32'd5,        32'd0,         32'd0,       1'b0, 1});
    vecs.push_back('{4'd1, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 32'd0,       1'b1, 1});
    vecs.push_back('{4'd0, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'd0,       1'b0, 1});
    vecs.push_back('{4'd2, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 32'd0,      1'b0, 1});
    vecs.push_back('{4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'd0,      1'b0, 1});
    vecs.push_back('{4'd4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 32'd0,      1'b0, 1});
    vecs.push_back('{4'd5, 32'hFFFF_FFFF, 32'd1,        32'd1,         32'd0,       1'b0, 1});
    vecs.push_back('{4'd5, 32'd1,         32'hFFFF_FFFF, 32'd0,        32'd0,       1'b0, 1});
    vecs.push_back('{4'd6, 32'd1,         32'd31,       32'h8000_0000, 32'd0,       1'b0, 32});
    vecs.push_back('{4'd7, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 32'd0,       1'b0, 1});
    vecs.push_back('{4'd7, 32'h8000_0000, 32'h24,       32'h0800_0000, 32'd0,       1'b0, 5});
    vecs.push_back('{4'd8, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE, 32'd1,       1'b1, 33});
    vecs.push_back('{4'd8, 32'd12345,     32'd678,      32'd8369910,   32'd0,       1'b0, 33});
    vecs.push_back('{4'd15, 32'd5,        32'd3,        32'd0,         32'd0,       1'b0, 1});
`ifdef MC_ALU_DIV_EN
    vecs.push_back('{4'd9, 32'd100,       32'd7,        32'd14,        32'd2,       1'b0, 33});
    vecs.push_back('{4'd9, 32'd100,       32'd0,        32'hFFFF_FFFF, 32'd100,     1'b1, 1});
`else
    vecs.push_back('{4'd9, 32'd100,       32'd7,        32'd0,         32'd0,       1'b0, 1});
    vecs.push_back('{4'd9, 32'd100,       32'd0,        32'd0,         32'd0,       1'b0, 1});
`endif

    // Reset state
    #12;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.result_hi", 64'(result_hi), 64'd0);
    chk("rst.zero", 64'(zero), 64'd1);
    chk("rst.overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, issued back-to-back
    foreach (vecs[i])
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].r, vecs[i].h, vecs[i].v, vecs[i].lat, 0);

    // Start pulsed mid-MULU must be ignored
    run_vec("mul_poke", 4'd8, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b1, 33, 5);
    // Back-to-back ADD then AND: second accepted in the done cycle, one edge later
    run_vec("b2b_add", 4'd0, 32'd3, 32'd4, 32'd7, 32'd0, 1'b0, 1, 0);
    run_vec("b2b_and", 4'd3, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_000F, 32'd0, 1'b0, 1, 0);

    // Reset mid-MULU, 10 cycles in
    @(negedge clk);
    op = 4'd8; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.result", 64'(result), 64'd0);
    chk("midrst.result_hi", 64'(result_hi), 64'd0);
    chk("midrst.zero", 64'(zero), 64'd1);
    chk("midrst.overflow", 64'(overflow), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("midrst.no_done", 64'(seen_done), 64'd0);
    run_vec("after_rst_add", 4'd0, 32'd10, 32'd20, 32'd30, 32'd0, 1'b0, 1, 0);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 10);
      ro = (k == 10) ? 4'($urandom_range(10, 15)) : 4'(k);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      model(ro, ra, rb, er, eh, ev, el);
      run_vec($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, er, eh, ev, el, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
